// File: rtl/proc_debug_pkg.sv
// rtl/proc_debug_pkg.sv - shared encodings and trace record layout for the debug controller
package proc_debug_pkg;

  localparam int TRACE_W = 103;
  localparam int CMD_W   = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_STEP  = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_HALT  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STEP_EXEC = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  // The named fields total 102 bits; the spare MSB keeps the record at TRACE_W and reads as 0.
  typedef struct packed {
    logic        rsvd;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/proc_debug_ctrl_if.sv
// rtl/proc_debug_ctrl_if.sv - command, trace-capture and trace-readout signals of the debug controller
interface proc_debug_ctrl_if;
  import proc_debug_pkg::*;

  logic               cmd_val;
  logic [CMD_W-1:0]   cmd;
  logic               trace_val;
  logic [31:0]        trace_addr;
  logic [31:0]        trace_inst;
  logic               trace_wen;
  logic [4:0]         trace_wreg;
  logic [31:0]        trace_wdata;
  logic               rd_val;
  logic               rd_rdy;
  logic [TRACE_W-1:0] rd_data;

  modport master (
    output cmd_val, cmd, trace_val, trace_addr, trace_inst, trace_wen, trace_wreg, trace_wdata, rd_rdy,
    input  rd_val, rd_data
  );

  modport slave (
    input  cmd_val, cmd, trace_val, trace_addr, trace_inst, trace_wen, trace_wreg, trace_wdata, rd_rdy,
    output rd_val, rd_data
  );

endinterface

// File: rtl/proc_debug_tracebuf.sv
// rtl/proc_debug_tracebuf.sv - overwrite-oldest circular trace buffer with val/rdy readout
module proc_debug_tracebuf
  import proc_debug_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               wr_val_i,
  input  logic [TRACE_W-1:0] wr_data_i,
  output logic               rd_val_o,
  input  logic               rd_rdy_i,
  output logic [TRACE_W-1:0] rd_data_o,
  output logic               overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TRACE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               full, pop;

  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign rd_val_o   = (count_q != '0);
  assign pop        = rd_val_o && rd_rdy_i;
  assign rd_data_o  = mem_q[head_q];
  assign overflow_o = ovf_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_val_i) tail_d = tail_q + PTR_W'(1);
      // A write into a full buffer without a pop drops the oldest entry.
      if (pop || (wr_val_i && full)) head_d = head_q + PTR_W'(1);
      if (wr_val_i && !pop) begin
        if (full) ovf_d = 1'b1;
        else      count_d = count_q + (PTR_W+1)'(1);
      end else if (!wr_val_i && pop) begin
        count_d = count_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_val_i && !clear_i) mem_q[tail_q] <= wr_data_i;
  end

endmodule

// File: rtl/proc_debug_ctrl.sv
// rtl/proc_debug_ctrl.sv - run-control FSM, cycle budget and trace capture; PROC_DEBUG_BREAKPOINT_EN adds a PC breakpoint in RUN
module proc_debug_ctrl
  import proc_debug_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 500,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  proc_debug_ctrl_if.slave dbg,
`ifdef PROC_DEBUG_BREAKPOINT_EN
  input  logic             bp_val,
  input  logic [31:0]      bp_addr,
`endif
  input  logic             done_in,
  output logic             proc_en,
  output logic             overflow,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] total_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic             proc_en_q, proc_en_d;
  logic [CNT_W-1:0] total_q, total_d, ccnt_q, ccnt_d;
  cmd_e             cmd_in;
  logic             is_step, is_run, is_halt, is_clear;
  logic             limit_hit, bp_hit;
  trace_entry_t     wr_entry;

  assign cmd_in   = cmd_e'(dbg.cmd);
  assign is_step  = dbg.cmd_val && (cmd_in == CMD_STEP);
  assign is_run   = dbg.cmd_val && (cmd_in == CMD_RUN);
  assign is_halt  = dbg.cmd_val && (cmd_in == CMD_HALT);
  assign is_clear = dbg.cmd_val && (cmd_in == CMD_CLEAR);

`ifdef PROC_DEBUG_BREAKPOINT_EN
  assign bp_hit = dbg.trace_val && bp_val && (dbg.trace_addr == bp_addr);
`else
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    total_d = total_q;
    ccnt_d  = ccnt_q;
    if (is_clear) begin
      total_d = '0;
      ccnt_d  = '0;
    end else if (proc_en_q) begin
      if (total_q != CNT_MAX)             total_d = total_q + CNT_W'(1);
      if (!done_in && (ccnt_q != CNT_MAX)) ccnt_d  = ccnt_q + CNT_W'(1);
    end
  end

  assign limit_hit = proc_en_q && (total_d == LIMIT);

  // CLEAR beats the budget; the budget beats every other command and the breakpoint.
  always_comb begin
    state_d = state_q;
    if (is_clear) begin
      state_d = ST_IDLE;
    end else if (limit_hit) begin
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_step)     state_d = ST_STEP_EXEC;
          else if (is_run) state_d = ST_RUN;
        end
        ST_STEP_EXEC: state_d = ST_STEP_WAIT;
        ST_STEP_WAIT: begin
          if (is_step)      state_d = ST_STEP_EXEC;
          else if (is_run)  state_d = ST_RUN;
          else if (is_halt) state_d = ST_DONE;
        end
        ST_RUN: begin
          if (is_halt)                state_d = ST_DONE;
          else if (is_step || bp_hit) state_d = ST_STEP_WAIT;
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    proc_en_d = (state_d == ST_STEP_EXEC) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      proc_en_q <= 1'b0;
      total_q   <= '0;
      ccnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      proc_en_q <= proc_en_d;
      total_q   <= total_d;
      ccnt_q    <= ccnt_d;
    end
  end

  assign wr_entry = {1'b0, dbg.trace_addr, dbg.trace_inst, dbg.trace_wen, dbg.trace_wreg, dbg.trace_wdata};

  proc_debug_tracebuf #(.DEPTH(DEPTH)) u_tracebuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (is_clear),
    .wr_val_i   (proc_en_q && dbg.trace_val),
    .wr_data_i  (wr_entry),
    .rd_val_o   (dbg.rd_val),
    .rd_rdy_i   (dbg.rd_rdy),
    .rd_data_o  (dbg.rd_data),
    .overflow_o (overflow)
  );

  assign proc_en      = proc_en_q;
  assign state        = state_q;
  assign cycle_count  = ccnt_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_proc_debug_ctrl.sv
// tb/tb_proc_debug_ctrl.sv - directed and random checks of proc_debug_ctrl against a queue-based reference model
module tb_proc_debug_ctrl;
  import proc_debug_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXC  = 20;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             done_in = 1'b0;
  logic             proc_en, overflow;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count, total_cycles;
`ifdef PROC_DEBUG_BREAKPOINT_EN
  logic             bp_val = 1'b0;
  logic [31:0]      bp_addr = 32'h0;
`endif

  proc_debug_ctrl_if dbg ();

  proc_debug_ctrl #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dbg          (dbg),
`ifdef PROC_DEBUG_BREAKPOINT_EN
    .bp_val       (bp_val),
    .bp_addr      (bp_addr),
`endif
    .done_in      (done_in),
    .proc_en      (proc_en),
    .overflow     (overflow),
    .state        (state),
    .cycle_count  (cycle_count),
    .total_cycles (total_cycles)
  );

  // Reference model: plain integers for the mode and a queue for the trace buffer.
  int               m_state;
  logic [CNT_W-1:0] m_total, m_ccnt;
  bit               m_ovf;
  logic [102:0]     m_q [$];
  int               n_chk = 0;
  int               n_bad = 0;
  int               en_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_total = '0;
    m_ccnt  = '0;
    m_ovf   = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit en, wr, pop, cv, bp;
    int c;
    en  = (m_state == 1) || (m_state == 3);
    wr  = en && dbg.trace_val;
    pop = (m_q.size() != 0) && dbg.rd_rdy;
    cv  = dbg.cmd_val;
    c   = int'(dbg.cmd);
    bp  = 1'b0;
`ifdef PROC_DEBUG_BREAKPOINT_EN
    bp  = dbg.trace_val && bp_val && (dbg.trace_addr == bp_addr);
`endif
    if (cv && c == 3) begin
      model_reset();
      return;
    end
    if (en) begin
      if (m_total != '1) m_total = m_total + 1;
      if (!done_in && m_ccnt != '1) m_ccnt = m_ccnt + 1;
    end
    if (pop) void'(m_q.pop_front());
    if (wr) m_q.push_back({1'b0, dbg.trace_addr, dbg.trace_inst, dbg.trace_wen, dbg.trace_wreg, dbg.trace_wdata});
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
    if (en && m_total == MAXC) m_state = 4;
    else begin
      case (m_state)
        0: if (cv && c == 0) m_state = 1; else if (cv && c == 1) m_state = 3;
        1: m_state = 2;
        2: if (cv && c == 0) m_state = 1; else if (cv && c == 1) m_state = 3; else if (cv && c == 2) m_state = 4;
        3: if (cv && c == 2) m_state = 4; else if ((cv && c == 0) || bp) m_state = 2;
        default: m_state = 4;
      endcase
    end
  endtask

  task automatic check_all();
    chk("state", state, m_state);
    chk("proc_en", proc_en, (m_state == 1) || (m_state == 3));
    chk("total_cycles", total_cycles, m_total);
    chk("cycle_count", cycle_count, m_ccnt);
    chk("overflow", overflow, m_ovf);
    chk("rd_val", dbg.rd_val, m_q.size() != 0);
    if (m_q.size() != 0) chk("rd_data", dbg.rd_data, m_q[0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send(input cmd_e c);
    dbg.cmd_val = 1'b1;
    dbg.cmd     = c;
    tick();
    dbg.cmd_val = 1'b0;
  endtask

  task automatic set_trace(input logic [31:0] a);
    dbg.trace_addr  = a;
    dbg.trace_inst  = $urandom;
    dbg.trace_wen   = 1'($urandom);
    dbg.trace_wreg  = 5'($urandom);
    dbg.trace_wdata = $urandom;
  endtask

  initial begin
    dbg.cmd_val   = 1'b0;
    dbg.cmd       = CMD_STEP;
    dbg.trace_val = 1'b0;
    dbg.rd_rdy    = 1'b0;
    set_trace(32'h0);
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-step: three one-cycle enables, entries read back in order.
    send(CMD_CLEAR);
    dbg.trace_val = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      send(CMD_STEP);
      en_cnt += int'(proc_en);
      set_trace(32'(i * 4));
      tick();
      en_cnt += int'(proc_en);
      tick();
      en_cnt += int'(proc_en);
    end
    chk("step_en_cycles", 128'(en_cnt), 3);
    chk("step_state", state, 3'd2);
    dbg.trace_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("step_pop_addr", dbg.rd_data[101:70], 32'(i * 4));
      dbg.rd_rdy = 1'b1;
      tick();
      dbg.rd_rdy = 1'b0;
    end
    chk("step_empty", dbg.rd_val, 1'b0);

    // Run into the cycle budget with done_in rising after 12 enabled cycles.
    send(CMD_CLEAR);
    send(CMD_RUN);
    for (int i = 0; i < 25; i++) begin
      done_in       = (m_total >= 12);
      dbg.trace_val = 1'($urandom);
      dbg.rd_rdy    = 1'($urandom);
      set_trace($urandom);
      tick();
    end
    chk("limit_total", total_cycles, 20);
    chk("limit_ccnt", cycle_count, 12);
    chk("limit_state", state, 3'd4);
    chk("limit_proc_en", proc_en, 1'b0);
    done_in = 1'b0;
    send(CMD_RUN);
    chk("done_ignores_run", state, 3'd4);

    // Overflow: six captures into four slots with nobody reading.
    send(CMD_CLEAR);
    dbg.rd_rdy    = 1'b0;
    dbg.trace_val = 1'b1;
    send(CMD_RUN);
    for (int i = 0; i < 6; i++) begin
      set_trace(32'(i * 4));
      if (i == 5) begin
        dbg.cmd_val = 1'b1;
        dbg.cmd     = CMD_HALT;
      end
      tick();
      dbg.cmd_val = 1'b0;
    end
    chk("ovf_flag", overflow, 1'b1);
    dbg.trace_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_addr", dbg.rd_data[101:70], 32'((i + 2) * 4));
      dbg.rd_rdy = 1'b1;
      tick();
      dbg.rd_rdy = 1'b0;
    end
    chk("ovf_drained", dbg.rd_val, 1'b0);

    // Full buffer with a push and a pop every cycle.
    send(CMD_CLEAR);
    dbg.trace_val = 1'b1;
    send(CMD_RUN);
    for (int i = 0; i < 10; i++) begin
      dbg.rd_rdy = (i >= 4);
      set_trace(32'h100 + 32'(i * 4));
      tick();
    end
    chk("pushpop_no_ovf", overflow, 1'b0);
    chk("pushpop_head", dbg.rd_data[101:70], 32'h100 + 32'(6 * 4) - 32'(4 * 4) + 32'(4 * 4) - 32'h0);
    send(CMD_HALT);

    // Random command and trace traffic.
    for (int i = 0; i < 400; i++) begin
      dbg.cmd_val   = ($urandom_range(0, 4) == 0);
      dbg.cmd       = cmd_e'($urandom_range(0, 3));
      done_in       = 1'($urandom);
      dbg.trace_val = 1'($urandom);
      dbg.rd_rdy    = ($urandom_range(0, 2) == 0);
`ifdef PROC_DEBUG_BREAKPOINT_EN
      bp_val  = 1'($urandom);
      bp_addr = 32'h10;
`endif
      set_trace(32'($urandom_range(0, 7) * 4));
      tick();
    end
    dbg.cmd_val = 1'b0;
    done_in     = 1'b0;
`ifdef PROC_DEBUG_BREAKPOINT_EN
    bp_val = 1'b0;
`endif

    // Asynchronous reset in the middle of a run.
    send(CMD_CLEAR);
    dbg.rd_rdy    = 1'b0;
    dbg.trace_val = 1'b1;
    send(CMD_RUN);
    for (int i = 0; i < 3; i++) begin
      set_trace(32'(i * 4));
      tick();
    end
    chk("prereset_rd_val", dbg.rd_val, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_proc_en", proc_en, 1'b0);
    chk("areset_rd_val", dbg.rd_val, 1'b0);
    chk("areset_total", total_cycles, 0);
    chk("areset_ccnt", cycle_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CLEAR while running returns to IDLE on the next edge.
    send(CMD_RUN);
    tick();
    tick();
    send(CMD_CLEAR);
    chk("clear_in_run", state, 3'd0);

`ifdef PROC_DEBUG_BREAKPOINT_EN
    dbg.rd_rdy = 1'b0;
    bp_val     = 1'b1;
    bp_addr    = 32'h10;
    send(CMD_RUN);
    for (int i = 2; i < 5; i++) begin
      set_trace(32'(i * 4));
      tick();
    end
    chk("bp_state", state, 3'd2);
    chk("bp_proc_en", proc_en, 1'b0);
    dbg.trace_val = 1'b0;
    tick();
    chk("bp_still_waiting", proc_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_addr", dbg.rd_data[101:70], 32'((i + 2) * 4));
      dbg.rd_rdy = 1'b1;
      tick();
      dbg.rd_rdy = 1'b0;
    end
    bp_val = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
